// File: rtl/mips_pkg.sv
// mips_pkg: shared loader state encoding and instruction-format constants
package mips_pkg;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } loader_state_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: big-endian packing of a byte stream into words, completion flagged with the 4th byte
module byte_packer
  import mips_pkg::*;
(
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     clear,
  input  logic                     accept,
  input  logic [7:0]               data,
  output logic [8*INSTR_BYTES-1:0] word,
  output logic                     word_valid
);
  logic [1:0]                     cnt;
  logic [8*(INSTR_BYTES-1)-1:0]   sr;
  // The 4th byte is merged combinationally so the word can be registered on the edge that accepts it
  assign word       = {sr, data};
  assign word_valid = accept && cnt == 2'd3;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt <= 2'd0;
      sr  <= '0;
    end else if (clear) begin
      cnt <= 2'd0;
    end else if (accept) begin
      cnt <= cnt + 2'd1;
      sr  <= {sr[8*(INSTR_BYTES-2)-1:0], data};
    end
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: loads instruction memory from a serial byte stream until HALT or overflow
module instr_loader
  import mips_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 64,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [7:0]                     i_rx_data,
  input  logic                           i_rx_valid,
  output logic [DATA_WIDTH-1:0]          o_instruccion,
  output logic [DATA_WIDTH-1:0]          o_address,
  output logic                           o_loading,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_error,
  output logic [$clog2(MEM_DEPTH+1)-1:0] o_word_count
);
  localparam int CW = $clog2(MEM_DEPTH+1);
  loader_state_t         state, next;
  logic                  start, accept, word_valid, full, write;
  logic [DATA_WIDTH-1:0] word, addr;
  assign start  = i_start && state != RECV;
  assign accept = i_rx_valid && state == RECV;
  assign full   = o_word_count == CW'(MEM_DEPTH);
  assign write  = word_valid && !full;
  byte_packer u_packer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .clear     (start),
    .accept    (accept),
    .data      (i_rx_data),
    .word      (word),
    .word_valid(word_valid)
  );
  always_comb begin
    next = state;
    if (start) next = RECV;
    else if (word_valid) next = full ? ERROR : (word == HALT_WORD ? DONE : RECV);
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else state <= next;
  end
  // Count and address advance while the strobe is out, so the strobe carries the pre-increment address
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_loading     <= 1'b0;
      o_instruccion <= '0;
      o_address     <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_word_count  <= '0;
      addr          <= '0;
    end else begin
      o_loading <= write;
      o_busy    <= next == RECV;
      o_done    <= next == DONE;
      o_error   <= next == ERROR;
      if (write) begin
        o_instruccion <= word;
        o_address     <= addr;
      end
      if (start) begin
        addr         <= '0;
        o_word_count <= '0;
      end else if (o_loading) begin
        addr         <= addr + DATA_WIDTH'(INSTR_BYTES);
        o_word_count <= o_word_count + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed and random sessions checked against a byte-queue model of the loader
module tb_instr_loader;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
  logic          i_clock = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_rx_valid = 1'b0;
  logic [7:0]    i_rx_data = 8'h00;
  logic [31:0]   o_instruccion, o_address;
  logic          o_loading, o_busy, o_done, o_error;
  logic [CW-1:0] o_word_count;

  instr_loader #(.MEM_DEPTH(DEPTH)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_instruccion(o_instruccion),
    .o_address    (o_address),
    .o_loading    (o_loading),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_word_count (o_word_count)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
    int          cyc;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] m_bytes[$];
  bit         m_busy, m_done, m_err;
  int         m_count;
  int         cyc = 0;
  int         checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance one clock; every cycle either a predicted write appears or no strobe does
  task automatic tick();
    @(posedge i_clock);
    cyc++;
    @(negedge i_clock);
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      chk("strobe", 32'(o_loading), 32'd1);
      chk("instr", o_instruccion, exp_q[0].word);
      chk("addr", o_address, exp_q[0].addr);
      void'(exp_q.pop_front());
    end else begin
      chk("no_strobe", 32'(o_loading), 32'd0);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    if (!m_busy) return;
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
      m_bytes.delete();
      if (m_count == DEPTH) begin
        m_busy = 0;
        m_err  = 1;
      end else begin
        exp_q.push_back('{w, 32'(4 * m_count), cyc + 1});
        m_count++;
        if (w == 32'hFFFF_FFFF) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    model_byte(b);
    tick();
    i_rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i+:8], gap);
  endtask

  task automatic start();
    i_start = 1'b1;
    if (!m_busy) begin
      m_busy  = 1;
      m_done  = 0;
      m_err   = 0;
      m_count = 0;
      m_bytes.delete();
    end
    tick();
    i_start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_loading"}, 32'(o_loading), 32'd0);
    chk({tag, "_instr"}, o_instruccion, 32'd0);
    chk({tag, "_addr"}, o_address, 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
    chk({tag, "_error"}, 32'(o_error), 32'd0);
    chk({tag, "_count"}, 32'(o_word_count), 32'd0);
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    #1;
    check_zero("reset");
    m_busy  = 0;
    m_done  = 0;
    m_err   = 0;
    m_count = 0;
    m_bytes.delete();
    exp_q.delete();
    tick();
    i_reset = 1'b1;
    tick();
  endtask

  task automatic check_status(input string tag);
    repeat (2) tick();
    chk({tag, "_busy"}, 32'(o_busy), 32'(m_busy));
    chk({tag, "_done"}, 32'(o_done), 32'(m_done));
    chk({tag, "_error"}, 32'(o_error), 32'(m_err));
    chk({tag, "_count"}, 32'(o_word_count), 32'(m_count));
  endtask

  initial begin
    #1 i_reset = 1'b0;
    repeat (2) tick();
    check_zero("init");
    i_reset = 1'b1;
    tick();
    // reset mid-word discards the partial bytes
    start();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    do_reset();
    start();
    send_word(32'h0000_0001, 1);
    check_status("t1");
    // basic load ending in HALT, done alongside the last strobe
    do_reset();
    start();
    send_word(32'h2001_0005, 1);
    send_word(32'h8C02_0004, 0);
    send_word(32'hFFFF_FFFF, 0);
    chk("t2_done_with_strobe", 32'(o_done), 32'd1);
    check_status("t2");
    // back-to-back bytes
    start();
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i), 0);
    check_status("t3");
    send_word(32'hFFFF_FFFF, 0);
    check_status("t3_end");
    // overflow
    start();
    for (int i = 0; i < 5; i++) send_word(32'h1000_0000 + 32'(i), 0);
    check_status("t4");
    chk("t4_error", 32'(o_error), 32'd1);
    chk("t4_count", 32'(o_word_count), 32'd4);
    // halt in the last slot
    start();
    for (int i = 0; i < 3; i++) send_word(32'h2000_0000 + 32'(i), 1);
    send_word(32'hFFFF_FFFF, 0);
    check_status("t5");
    chk("t5_done", 32'(o_done), 32'd1);
    chk("t5_error", 32'(o_error), 32'd0);
    // bytes before start ignored, start during a session ignored, restart from DONE at address 0
    send_word(32'h3344_5566, 0);
    start();
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    start();
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_word(32'hFFFF_FFFF, 2);
    check_status("t6");
    // random sessions
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(0, 3) == 0) send_word($urandom, $urandom_range(0, 1));
      start();
      for (int w = 0, n = $urandom_range(1, 6); w < n; w++) begin
        if ($urandom_range(0, 7) == 0) start();
        if ($urandom_range(0, 15) == 0) do_reset();
        send_word(($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom_range(0, 2));
      end
      check_status("rand");
    end
    repeat (3) tick();
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
